fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each requester's data word and of the FIFO write data.
REQ-002 Parameter NUM_REQ, default 4, legal range 2..8: number of write requesters.
REQ-003 Port clk  input  1: single clock; all logic samples on the rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low.
REQ-005 Port req  input  NUM_REQ: per-requester write request; held high until granted.
REQ-006 Port req_data  input  NUM_REQ*DATA_WIDTH: requester i's data occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; held stable while req[i]=1.
REQ-007 Port gnt  output  NUM_REQ: one-hot grant; high for one cycle.
REQ-008 Port wr_en  output  1: FIFO write enable.
REQ-009 Port data_in  output  DATA_WIDTH: FIFO write data.
REQ-010 Port full, almostfull  input  1 each: FIFO status flags, registered by the FIFO.
REQ-011 Port wr_ack, overflow  input  1 each: FIFO write response, valid the cycle after wr_en.
REQ-012 Port ovf_cnt  output  8: overflow event count (see Configuration).

Function
REQ-013 All outputs (wr_en, gnt, data_in, ovf_cnt) shall be registered.
REQ-014 Arbitration shall be round-robin: search starts at last_gnt+1 mod NUM_REQ; first asserted, unmasked req wins.
REQ-015 In any cycle, gnt[i]=1 shall coincide with wr_en=1 and data_in = req_data slice i as sampled at the preceding edge.
REQ-016 The requester granted in cycle t shall be masked from the decision made at the end of cycle t. Consequence: no requester is granted in two consecutive cycles.
REQ-017 Write permission at edge ending cycle t: full=0 AND NOT (almostfull=1 AND wr_en=1 in cycle t).
REQ-018 States:
- IDLE: no unmasked request.
- WRITE: grant issued this cycle.
- STALL: unmasked request pending but permission denied.
REQ-019 Transitions:
- IDLE/WRITE/STALL -> WRITE when a winner exists and permission holds.
- -> STALL when a winner exists but permission is denied.
- -> IDLE otherwise.
REQ-020 In STALL, wr_en and gnt shall be 0, and last_gnt and the pending winner choice shall be frozen; the winner is re-evaluated only when permission returns.
REQ-021 A request that deasserts while not granted is dropped with no side effect; requesters shall not do this, and the arbiter shall not check it.
REQ-022 The last_gnt pointer shall wrap from NUM_REQ-1 to 0.
REQ-023 Back-to-back grants to different requesters shall sustain one write per cycle while permission holds.

Reset
REQ-024 Reset values while rst_n=0 at a rising edge:
- wr_en=0, gnt=0, data_in=0, ovf_cnt=0.
- state=IDLE, last_gnt=NUM_REQ-1, so requester 0 has first priority.
REQ-025 Reset asserted mid-write shall cancel any grant from the following cycle on. The write already presented to the FIFO is not retracted.
REQ-026 The first grant after rst_n rises shall occur no earlier than the cycle following the first sampling edge with rst_n=1.

Configuration
REQ-027 Macro FIFO_ARB_OVF_CNT_EN.
- Defined: ovf_cnt increments by 1 on each cycle where overflow=1 or (wr_en was 1 in the previous cycle and wr_ack=0); it saturates at 255 and clears only on reset.
- Undefined: ovf_cnt is constant 0 and no counter logic is synthesized.

Verification
REQ-028 Single requester: req=4'b0001, req_data[15:0]=16'hA5A5, FIFO empty -> the cycle after the first sampling edge, gnt=4'b0001, wr_en=1, data_in=16'hA5A5. The next cycle is masked: wr_en=0.
REQ-029 All four request continuously, FIFO never full -> grant order 0,1,2,3,0,... with wr_en high every cycle.
REQ-030 Full guard: almostfull=1 with a grant in cycle t -> no wr_en in t+1; full=1 -> state STALL, wr_en=0 until full=0, then the frozen winner is granted first.
REQ-031 Reset during stream: rst_n=0 for one edge mid-sequence -> gnt=0 and wr_en=0 next cycle; after release, requester 0 wins first.
REQ-032 With FIFO_ARB_OVF_CNT_EN defined: force overflow=1 for 3 cycles -> ovf_cnt=3; force it for 300 cycles -> ovf_cnt=255. With the macro undefined: ovf_cnt stays 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ write requesters into one FIFO write port.
// Define FIFO_ARB_OVF_CNT_EN to build the saturating overflow event counter.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          full,
    input  logic                          almostfull,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic [7:0]                    ovf_cnt
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, WRITE, STALL} state_t;

    state_t                  state;
    logic [IW-1:0]           last_gnt;
    logic [IW-1:0]           pend_idx;

    logic [NUM_REQ-1:0]      cand;
    logic                    rr_found;
    logic [IW-1:0]           rr_idx;
    logic                    found;
    logic [IW-1:0]           win;
    logic [NUM_REQ-1:0]      win_oh;
    logic [DATA_WIDTH-1:0]   win_data;
    logic                    permit;

    // The requester granted this cycle is masked; in STALL gnt is 0 so nothing is.
    assign cand   = req & ~gnt;
    assign permit = !full && !(almostfull && wr_en);

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IW-1:0] j;
            j = IW'((int'(last_gnt) + k) % NUM_REQ);
            if (!rr_found && cand[j]) begin
                rr_found = 1'b1;
                rr_idx   = j;
            end
        end
    end

    // A stalled winner keeps its slot; late arrivals closer to the pointer must not jump it.
    always_comb begin
        if (state == STALL && req[pend_idx]) begin
            found = 1'b1;
            win   = pend_idx;
        end else begin
            found = rr_found;
            win   = rr_idx;
        end
    end

    always_comb begin
        win_oh   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IW'(i)) begin
                win_oh[i] = 1'b1;
                win_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= IW'(NUM_REQ - 1);
            pend_idx <= '0;
            gnt      <= '0;
            wr_en    <= 1'b0;
            data_in  <= '0;
        end else if (found && permit) begin
            state    <= WRITE;
            last_gnt <= win;
            gnt      <= win_oh;
            wr_en    <= 1'b1;
            data_in  <= win_data;
        end else if (found) begin
            state    <= STALL;
            pend_idx <= win;
            gnt      <= '0;
            wr_en    <= 1'b0;
        end else begin
            state    <= IDLE;
            gnt      <= '0;
            wr_en    <= 1'b0;
        end
    end

`ifdef FIFO_ARB_OVF_CNT_EN
    logic wr_en_q;

    // wr_ack answers the previous cycle's write, so compare against delayed wr_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            ovf_cnt <= 8'd0;
        end else begin
            wr_en_q <= wr_en;
            if ((overflow || (wr_en_q && !wr_ack)) && ovf_cnt != 8'hFF)
                ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{overflow, wr_ack};
    assign ovf_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table for arbitration/flow control,
// plus hand sequences for mid-stream reset and the overflow counter.
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic        wr_en;
    logic [15:0] data_in;
    logic        full, almostfull, wr_ack, overflow;
    logic [7:0]  ovf_cnt;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .wr_en(wr_en), .data_in(data_in),
        .full(full), .almostfull(almostfull), .wr_ack(wr_ack),
        .overflow(overflow), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       af;
        logic [3:0] gnt;
    } vec_t;

    vec_t        tbl[20];
    logic [15:0] slot_data[4];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_data(input logic [3:0] g);
        logic [15:0] d;
        d = 16'h0;
        for (int i = 0; i < 4; i++)
            if (g[i]) d = slot_data[i];
        return d;
    endfunction

    initial begin
        slot_data[0] = 16'hA5A5;
        slot_data[1] = 16'h2222;
        slot_data[2] = 16'h3333;
        slot_data[3] = 16'h4444;
        req_data = {slot_data[3], slot_data[2], slot_data[1], slot_data[0]};

        //              req      full  af    expected gnt
        tbl[0]  = '{4'b0001, 1'b0, 1'b0, 4'b0001};
        tbl[1]  = '{4'b0001, 1'b0, 1'b0, 4'b0000};  // masked after its grant
        tbl[2]  = '{4'b0001, 1'b0, 1'b0, 4'b0001};
        tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b0010};
        tbl[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0100};
        tbl[5]  = '{4'b1111, 1'b0, 1'b0, 4'b1000};
        tbl[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0001};  // pointer wraps
        tbl[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0010};
        tbl[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0000};  // almostfull after a write
        tbl[9]  = '{4'b1111, 1'b0, 1'b1, 4'b0100};  // no write last cycle -> allowed
        tbl[10] = '{4'b1000, 1'b0, 1'b1, 4'b0000};
        tbl[11] = '{4'b1000, 1'b1, 1'b0, 4'b0000};
        tbl[12] = '{4'b1000, 1'b1, 1'b0, 4'b0000};
        tbl[13] = '{4'b1000, 1'b0, 1'b0, 4'b1000};
        tbl[14] = '{4'b1111, 1'b0, 1'b0, 4'b0001};
        tbl[15] = '{4'b0100, 1'b0, 1'b1, 4'b0000};  // stall with winner 2
        tbl[16] = '{4'b0110, 1'b1, 1'b0, 4'b0000};
        tbl[17] = '{4'b0110, 1'b0, 1'b0, 4'b0100};  // frozen winner beats new req 1
        tbl[18] = '{4'b0010, 1'b0, 1'b0, 4'b0010};
        tbl[19] = '{4'b0000, 1'b0, 1'b0, 4'b0000};

        rst_n = 1'b0; req = 4'b0; full = 1'b0; almostfull = 1'b0;
        wr_ack = 1'b1; overflow = 1'b0;
        cyc(); cyc();
        chk("rst_gnt",     32'(gnt),     32'h0);
        chk("rst_wr_en",   32'(wr_en),   32'h0);
        chk("rst_data_in", 32'(data_in), 32'h0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            req = tbl[i].req; full = tbl[i].full; almostfull = tbl[i].af;
            cyc();
            chk($sformatf("v%0d_gnt", i),   32'(gnt),   32'(tbl[i].gnt));
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].gnt != 4'b0));
            if (tbl[i].gnt != 4'b0)
                chk($sformatf("v%0d_data", i), 32'(data_in), 32'(exp_data(tbl[i].gnt)));
        end
        full = 1'b0; almostfull = 1'b0;

        // Reset mid-stream: pointer currently at 1.
        req = 4'b1111;
        cyc(); chk("rs_pre0_gnt", 32'(gnt), 32'h4);
        cyc(); chk("rs_pre1_gnt", 32'(gnt), 32'h8);
        rst_n = 1'b0;
        cyc();
        chk("rs_gnt",   32'(gnt),   32'h0);
        chk("rs_wr_en", 32'(wr_en), 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("rs_first_gnt",  32'(gnt),     32'h1);
        chk("rs_first_data", 32'(data_in), 32'hA5A5);
        req = 4'b0000;
        cyc(); cyc();

        // Overflow counter.
        overflow = 1'b1;
        cyc(); cyc(); cyc();
        overflow = 1'b0;
        cyc();
`ifdef FIFO_ARB_OVF_CNT_EN
        chk("ovf_cnt_3", 32'(ovf_cnt), 32'd3);
`else
        chk("ovf_cnt_3", 32'(ovf_cnt), 32'd0);
`endif
        overflow = 1'b1;
        for (int i = 0; i < 300; i++) cyc();
        overflow = 1'b0;
        cyc();
`ifdef FIFO_ARB_OVF_CNT_EN
        chk("ovf_cnt_sat", 32'(ovf_cnt), 32'd255);
`else
        chk("ovf_cnt_sat", 32'(ovf_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
